mem_rd_stream: RTL and testbench
================================

Name: mem_rd_stream

Overview:
Sequential frame reader on the read port of the generic single-port-read/single-port-write memory. On `start` it scans an IMG_W x IMG_H pixel frame in raster order from a base address. It emits pixels as a valid/ready stream into the downstream convolution datapath. Row/frame markers travel with each beat, and a registered output stage hides the memory's combinational read path.

Parameters:
- ADDRW, 10, memory address width; must match the memory instance.
- DATAW, 8, pixel width; must match the memory instance.
- IMG_W, 32, pixels per row; range 1 to 2**ADDRW.
- IMG_H, 32, rows per frame; IMG_W*IMG_H must be <= 2**ADDRW (elaboration-time check, fatal otherwise).

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, begin a frame scan; sampled only in IDLE.
- base_addr, input, ADDRW, first pixel address; latched when start is accepted.
- busy, output, 1, high in RUN and DRAIN.
- done, output, 1, one-cycle pulse after the final beat is accepted.
- rd_addr, output, ADDRW, memory read address.
- rd_en, output, 1, read strobe; high only in cycles whose data is captured.
- rd_data, input, DATAW, memory read data; combinational in rd_addr, same cycle.
- out_data, output, DATAW, pixel.
- out_valid, output, 1, beat valid.
- out_ready, input, 1, downstream accept.
- out_eol, output, 1, beat is the last pixel of its row.
- out_eof, output, 1, beat is the last pixel of the frame.

Behaviour:
- Reset values (rst high at an edge):
  - state=IDLE.
  - out_valid, out_eol, out_eof, done, busy = 0.
  - out_data=0, rd_addr=0, rd_en=0.
  - All counters cleared.
- Reset mid-frame aborts the scan: no done, and the partial frame is discarded.
- States:
  - IDLE: start=1 at an edge → latch base_addr into the address counter, clear col/row, go to RUN. No other state reacts to start; it is ignored in RUN and DRAIN.
  - RUN: `load = !out_valid || out_ready`, computed combinationally.
    - rd_en = load. rd_addr = address counter at all times in RUN; don't-care (driven 0) elsewhere.
    - On an edge with load=1:
      - out_data <= rd_data; out_valid <= 1.
      - out_eol <= (col==IMG_W-1).
      - out_eof <= (col==IMG_W-1 && row==IMG_H-1).
      - Address counter increments modulo 2**ADDRW (natural wrap).
      - col increments; at IMG_W-1, col wraps to 0 and row increments.
      - If this was the final pixel → DRAIN.
  - DRAIN: rd_en=0. On the edge where out_valid && out_ready → out_valid <= 0, done <= 1 for exactly one cycle, state → IDLE.
- Latency:
  - start sampled at edge N → rd_en high during cycle N..N+1.
  - out_valid high from edge N+1.
  - With out_ready held high: one beat per cycle; IMG_W*IMG_H beats on consecutive cycles; done asserted at edge N+IMG_W*IMG_H+1.
- Stream rules:
  - Once out_valid=1, out_data, out_eol and out_eof hold stable until out_ready=1.
  - No pixel is dropped or duplicated under any out_ready pattern.
  - rd_en=0 in any cycle where out_valid=1 and out_ready=0.
- In IDLE, out_valid=0 (the last beat is already consumed in DRAIN).
- start coinciding with the done cycle: done is output in IDLE, so start is accepted; done and the new scan overlap harmlessly.
- IMG_W=1: every beat has out_eol=1.
- IMG_H=1: out_eof on the final beat only.
- Counter widths:
  - col is $clog2(IMG_W) bits, minimum 1.
  - row is $clog2(IMG_H) bits, minimum 1.
  - Comparisons are against IMG_W-1 and IMG_H-1 at full width.

Test Plan:
- **Full-rate scan.** Memory preloaded ram[a]=a[7:0]; IMG_W=4, IMG_H=2; base_addr=0; out_ready=1; start pulsed → 8 consecutive beats with data 0..7. out_eol on beats 3 and 7; out_eof on beat 7 only; done one cycle after beat 7; busy low afterwards.
- **Backpressure.** Same setup; out_ready pattern 1,0,0,1,0,1,1,0,... → accepted sequence exactly 0..7. out_data is stable during stalls. rd_en=0 in every stalled cycle with out_valid=1. done follows the 8th handshake.
- **Address wrap.** ADDRW=10; base_addr=1020; 4x2 frame → rd_addr sequence 1020,1021,1022,1023,0,1,2,3; data matches ram contents.
- **Start rules.** start re-asserted during RUN and during DRAIN → ignored, exactly 8 beats. start asserted in the done cycle → second frame begins with out_valid from the next edge, data restarting at base.
- **Mid-frame reset.** rst pulsed after 3 accepted beats → out_valid, busy and done are 0 after the edge, and done never pulses. A new start produces a full frame from beat 0.
- **Degenerate geometry.** IMG_W=1, IMG_H=3; base_addr=5 → beats 5,6,7. out_eol on all three beats; out_eof on the third only.

Source files
------------

// File: rtl/mem_rd_stream.sv
// mem_rd_stream: raster-order frame reader on the read port of a single-port memory.
// On start, it scans IMG_W x IMG_H pixels beginning at base_addr. It streams them out as
// valid/ready beats with end-of-row and end-of-frame markers. A registered output stage
// decouples the memory's combinational read path from the downstream consumer.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   start           - begin a frame scan (only honoured while idle)
//   base_addr       - first pixel address, latched when start is accepted
//   busy            - scan in progress (RUN or DRAIN)
//   done            - one-cycle pulse after the final beat is accepted
//   rd_addr, rd_en  - memory read address and strobe
//   rd_data         - memory read data, combinational in rd_addr
//   out_data        - pixel stream data
//   out_valid       - pixel stream valid
//   out_ready       - pixel stream ready
//   out_eol/out_eof - beat is the last pixel of its row / of the frame
module mem_rd_stream #(
    parameter int unsigned ADDRW = 10,
    parameter int unsigned DATAW = 8,
    parameter int unsigned IMG_W = 32,
    parameter int unsigned IMG_H = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDRW-1:0] base_addr,
    output logic             busy,
    output logic             done,
    output logic [ADDRW-1:0] rd_addr,
    output logic             rd_en,
    input  logic [DATAW-1:0] rd_data,
    output logic [DATAW-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_eol,
    output logic             out_eof
);

    localparam int unsigned COLW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROWW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // A frame larger than the address space would alias pixels onto each other.
    if ((IMG_W < 1) || (IMG_H < 1) ||
        (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDRW))) begin : g_size_check
        $fatal(1, "mem_rd_stream: IMG_W*IMG_H must be in 1..2**ADDRW");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic [ADDRW-1:0] addr_q,  addr_d;
    logic [COLW-1:0]  col_q,   col_d;
    logic [ROWW-1:0]  row_q,   row_d;
    logic [DATAW-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic             eol_q,   eol_d;
    logic             eof_q,   eof_d;
    logic             done_q,  done_d;

    logic load;
    logic last_col;
    logic last_row;

    assign last_col = (32'(col_q) == IMG_W - 1);
    assign last_row = (32'(row_q) == IMG_H - 1);

    // The output register can take a new pixel when empty or being drained this cycle.
    assign load = (state_q == StRun) && (!valid_q || out_ready);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        row_d   = row_q;
        data_d  = data_q;
        valid_d = valid_q;
        eol_d   = eol_q;
        eof_d   = eof_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    addr_d  = base_addr;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            StRun: begin
                if (load) begin
                    data_d  = rd_data;
                    valid_d = 1'b1;
                    eol_d   = last_col;
                    eof_d   = last_col && last_row;
                    addr_d  = addr_q + ADDRW'(1);
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + ROWW'(1);
                        if (last_row) begin
                            state_d = StDrain;
                        end
                    end else begin
                        col_d = col_q + COLW'(1);
                    end
                end
            end
            StDrain: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign rd_en     = load;
    assign rd_addr   = (state_q == StRun) ? addr_q : '0;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_eol   = eol_q;
    assign out_eof   = eof_q;

endmodule

// File: tb/tb_mem_rd_stream.sv
// Bench for mem_rd_stream: two instances (4x2 and 1x3 frames) share one stimulus stream.
// A per-instance reference model tracks pixels fetched and accepted. From these counts it
// predicts every output of every cycle.
module tb_mem_rd_stream;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic clk;
    logic rst;
    logic start;
    logic out_ready;
    logic [AW-1:0] base_addr;

    logic [1:0]         busy, done, rd_en, o_valid, o_eol, o_eof;
    logic [1:0][AW-1:0] rd_addr;
    logic [1:0][7:0]    rd_data, o_data;

    logic [7:0] ram [DEPTH];

    assign rd_data[0] = ram[rd_addr[0]];
    assign rd_data[1] = ram[rd_addr[1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_rd_stream #(.ADDRW(AW), .DATAW(8), .IMG_W(4), .IMG_H(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy[0]), .done(done[0]), .rd_addr(rd_addr[0]), .rd_en(rd_en[0]),
        .rd_data(rd_data[0]), .out_data(o_data[0]), .out_valid(o_valid[0]),
        .out_ready(out_ready), .out_eol(o_eol[0]), .out_eof(o_eof[0])
    );

    mem_rd_stream #(.ADDRW(AW), .DATAW(8), .IMG_W(1), .IMG_H(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy[1]), .done(done[1]), .rd_addr(rd_addr[1]), .rd_en(rd_en[1]),
        .rd_data(rd_data[1]), .out_data(o_data[1]), .out_valid(o_valid[1]),
        .out_ready(out_ready), .out_eol(o_eol[1]), .out_eof(o_eof[1])
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: frame geometry plus pixels fetched (loaded) and accepted (acc).
    int m_w[2];
    int m_n[2];
    int m_base[2];
    int m_loaded[2];
    int m_acc[2];
    bit m_active[2];
    bit m_done[2];

    logic [7:0] pat;

    task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, inst, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_done[i]   = 1'b0;
            m_loaded[i] = 0;
            m_acc[i]    = 0;
            m_base[i]   = 0;
        end
    endtask

    // Entered and left at posedge+1: drive inputs, check settled outputs, advance model.
    task automatic step(input logic rdy, input logic st);
        bit ev;
        bit er;
        bit hs;
        bit fin;
        int a;
        out_ready = rdy;
        start     = st;
        #1;
        for (int i = 0; i < 2; i++) begin
            ev = m_active[i] && (m_loaded[i] > m_acc[i]);
            er = m_active[i] && (m_loaded[i] < m_n[i]) && (!ev || rdy);
            chk("busy", i, 32'(busy[i]), 32'(m_active[i]));
            chk("out_valid", i, 32'(o_valid[i]), 32'(ev));
            chk("done", i, 32'(done[i]), 32'(m_done[i]));
            chk("rd_en", i, 32'(rd_en[i]), 32'(er));
            if (er) chk("rd_addr", i, 32'(rd_addr[i]), (m_base[i] + m_loaded[i]) % DEPTH);
            if (!m_active[i]) chk("rd_addr_idle", i, 32'(rd_addr[i]), 0);
            if (ev) begin
                a = (m_base[i] + m_acc[i]) % DEPTH;
                chk("out_data", i, 32'(o_data[i]), 32'(ram[a]));
                chk("out_eol", i, 32'(o_eol[i]), 32'((m_acc[i] % m_w[i]) == (m_w[i] - 1)));
                chk("out_eof", i, 32'(o_eof[i]), 32'(m_acc[i] == (m_n[i] - 1)));
            end
            hs  = ev && rdy;
            fin = hs && (m_acc[i] == m_n[i] - 1);
            if (er) m_loaded[i]++;
            if (hs) m_acc[i]++;
            if (fin) begin
                m_active[i] = 1'b0;
            end else if (!m_active[i] && st) begin
                m_active[i] = 1'b1;
                m_base[i]   = int'(base_addr);
                m_loaded[i] = 0;
                m_acc[i]    = 0;
            end
            m_done[i] = fin;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[k % 8];
        return logic'($urandom_range(0, 1));
    endfunction

    // One frame: start now, then run until both models are idle (bounded).
    task automatic run_frame(input int base, input int mode, input bit noise);
        logic st;
        base_addr = AW'(base);
        step(pick(mode, 0), 1'b1);
        for (int k = 1; k < 400; k++) begin
            if (!m_active[0] && !m_active[1]) break;
            st = noise && m_active[0] && ($urandom_range(0, 1) == 1);
            step(pick(mode, k), st);
        end
        chk("frame_complete", 0, 32'(m_active[0] || m_active[1]), 0);
    endtask

    initial begin
        pat = 8'b0110_1001;
        for (int a = 0; a < DEPTH; a++) ram[a] = 8'(a);
        m_w[0] = 4; m_n[0] = 8;
        m_w[1] = 1; m_n[1] = 3;
        model_reset();

        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        base_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 2; i++) begin
            chk("rst_out_data", i, 32'(o_data[i]), 0);
            chk("rst_rd_addr", i, 32'(rd_addr[i]), 0);
            chk("rst_rd_en", i, 32'(rd_en[i]), 0);
            chk("rst_out_valid", i, 32'(o_valid[i]), 0);
            chk("rst_out_eol", i, 32'(o_eol[i]), 0);
            chk("rst_out_eof", i, 32'(o_eof[i]), 0);
            chk("rst_busy", i, 32'(busy[i]), 0);
            chk("rst_done", i, 32'(done[i]), 0);
        end
        step(1'b1, 1'b0);

        // Full-rate scan, then a new start in the done cycle.
        run_frame(0, 0, 1'b0);
        chk("done_cycle", 0, 32'(done[0]), 1);
        run_frame(0, 0, 1'b0);
        repeat (2) step(1'b1, 1'b0);

        // Fixed backpressure pattern.
        run_frame(0, 1, 1'b0);
        step(1'b0, 1'b0);

        // Address wrap at the top of memory.
        run_frame(1020, 0, 1'b0);
        run_frame(1020, 2, 1'b0);

        // start re-asserted while busy must be ignored.
        run_frame(0, 1, 1'b1);
        run_frame(0, 2, 1'b1);

        // Degenerate 1x3 geometry on instance 1 reads 5,6,7.
        run_frame(5, 0, 1'b0);
        step(1'b0, 1'b0);

        // Mid-frame reset after three accepted beats.
        base_addr = AW'(100);
        step(1'b1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (m_acc[0] == 3) break;
            step(1'b1, 1'b0);
        end
        chk("pre_reset_beats", 0, 32'(m_acc[0]), 3);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk("abort_out_valid", i, 32'(o_valid[i]), 0);
            chk("abort_busy", i, 32'(busy[i]), 0);
            chk("abort_done", i, 32'(done[i]), 0);
        end
        repeat (3) step(1'b1, 1'b0);
        run_frame(100, 2, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            run_frame(int'($urandom_range(0, DEPTH - 1)), 2, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step(1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
